// File: rtl/cache_assoc_wb_pkg.sv
// Shared line type, FSM encoding and address field helpers for the write-back cache.
package cache_assoc_wb_pkg;

   localparam int LINE_OFFSET_W = 5;
   localparam int LINE_W        = 256;

   typedef logic [LINE_W-1:0] line_t;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      FILL
   } cache_state_e;

   function automatic logic [31:0] addr_set(input logic [31:0] addr, input int idx_w);
      return (addr >> LINE_OFFSET_W) & ((32'd1 << idx_w) - 32'd1);
   endfunction

   function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int idx_w);
      return addr >> (LINE_OFFSET_W + idx_w);
   endfunction

endpackage

// File: rtl/cache_assoc_wb_if.sv
// CPU-side line port and memory-side line port of the cache; master is the requester/memory
// environment, slave is the cache itself.
interface cache_assoc_wb_if;
   import cache_assoc_wb_pkg::*;

   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_byte_enable;
   line_t       mem_wdata;
   line_t       mem_rdata;
   logic        mem_resp;

   logic [31:0] pmem_address;
   logic        pmem_read;
   logic        pmem_write;
   line_t       pmem_wdata;
   line_t       pmem_rdata;
   logic        pmem_resp;

   modport master (
      output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, pmem_rdata, pmem_resp,
      input  mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
   );

   modport slave (
      input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, pmem_rdata, pmem_resp,
      output mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
   );

endinterface

// File: rtl/cache_assoc_wb_lru_ages.sv
// Per-set true-LRU ages (0 = most recent); touch lands on the next edge, victim lookup is
// combinational. No backpressure: a touch is applied whenever touch_vld is high.
module cache_lru_ages #(
   parameter int NUM_WAYS = 8,
   parameter int NUM_SETS = 8,
   parameter int WAY_W    = $clog2(NUM_WAYS),
   parameter int IDX_W    = $clog2(NUM_SETS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             touch_vld,
   input  logic [IDX_W-1:0] touch_set,
   input  logic [WAY_W-1:0] touch_way,
   input  logic [IDX_W-1:0] victim_set,
   output logic [WAY_W-1:0] victim_way
);

   logic [WAY_W-1:0] age [NUM_SETS][NUM_WAYS];
   logic [WAY_W-1:0] old_age;

   assign old_age = age[touch_set][touch_way];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
               age[s][w] <= WAY_W'(w);
            end
         end
      end else if (touch_vld) begin
         // Only younger ways age; older ones keep their rank, so ages stay a permutation.
         for (int w = 0; w < NUM_WAYS; w++) begin
            if (WAY_W'(w) == touch_way) begin
               age[touch_set][w] <= '0;
            end else if (age[touch_set][w] < old_age) begin
               age[touch_set][w] <= age[touch_set][w] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      victim_way = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (age[victim_set][w] == WAY_W'(NUM_WAYS - 1)) begin
            victim_way = WAY_W'(w);
         end
      end
   end

endmodule

// File: rtl/cache_assoc_wb.sv
// N-way write-back, write-allocate line cache. Hit: mem_resp same cycle; miss: optional
// write-back, then fill, then hit. Requests are held by the CPU until mem_resp.
module cache_assoc_wb
   import cache_assoc_wb_pkg::*;
#(
   parameter int NUM_WAYS = 8,
   parameter int NUM_SETS = 8
) (
   input logic             clk,
   input logic             rst,
   cache_assoc_wb_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int WAY_W = $clog2(NUM_WAYS);
   localparam int TAG_W = 32 - LINE_OFFSET_W - IDX_W;

   logic [TAG_W-1:0] tag_q   [NUM_SETS][NUM_WAYS];
   logic             valid_q [NUM_SETS][NUM_WAYS];
   logic             dirty_q [NUM_SETS][NUM_WAYS];
   line_t            data_q  [NUM_SETS][NUM_WAYS];

   cache_state_e     state, state_nxt;
   logic [IDX_W-1:0] set;
   logic [TAG_W-1:0] tag;
   logic             req, hit, any_invalid, wr_hit, rd_hit, miss_start, wb_done, fill_done;
   logic [WAY_W-1:0] hit_way, inv_way, lru_way, victim_sel, victim_q, victim_way;

   assign set        = IDX_W'(addr_set(bus.mem_address, IDX_W));
   assign tag        = TAG_W'(addr_tag(bus.mem_address, IDX_W));
   assign req        = bus.mem_read | bus.mem_write;
   assign rd_hit     = (state == IDLE) && req && hit;
   assign wr_hit     = rd_hit && bus.mem_write;
   assign miss_start = (state == IDLE) && req && !hit;
   assign wb_done    = (state == WRITEBACK) && bus.pmem_resp;
   assign fill_done  = (state == FILL) && bus.pmem_resp;

   // Descending scan so the lowest-index invalid way wins.
   always_comb begin
      hit         = 1'b0;
      hit_way     = '0;
      any_invalid = 1'b0;
      inv_way     = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (valid_q[set][w] && (tag_q[set][w] == tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[set][w]) begin
            any_invalid = 1'b1;
            inv_way     = WAY_W'(w);
         end
      end
   end

   assign victim_sel     = any_invalid ? inv_way : lru_way;
   assign victim_way     = (state == IDLE) ? victim_sel : victim_q;
   assign bus.mem_rdata  = hit ? data_q[set][hit_way] : data_q[set][victim_way];
   assign bus.pmem_wdata = data_q[set][victim_q];

   cache_lru_ages #(
      .NUM_WAYS (NUM_WAYS),
      .NUM_SETS (NUM_SETS)
   ) u_lru (
      .clk        (clk),
      .rst        (rst),
      .touch_vld  (rd_hit),
      .touch_set  (set),
      .touch_way  (hit_way),
      .victim_set (set),
      .victim_way (lru_way)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         victim_q <= '0;
      end else begin
         state <= state_nxt;
         if (miss_start) begin
            victim_q <= victim_sel;
         end
      end
   end

   always_comb begin
      state_nxt        = state;
      bus.mem_resp     = 1'b0;
      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.pmem_address = {tag, set, {LINE_OFFSET_W{1'b0}}};
      case (state)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  bus.mem_resp = 1'b1;
               end else if (valid_q[set][victim_sel] && dirty_q[set][victim_sel]) begin
                  state_nxt = WRITEBACK;
               end else begin
                  state_nxt = FILL;
               end
            end
         end
         WRITEBACK: begin
            bus.pmem_write   = 1'b1;
            bus.pmem_address = {tag_q[set][victim_q], set, {LINE_OFFSET_W{1'b0}}};
            if (bus.pmem_resp) begin
               state_nxt = FILL;
            end
         end
         FILL: begin
            bus.pmem_read = 1'b1;
            if (bus.pmem_resp) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               dirty_q[s][w] <= 1'b0;
            end
         end
      end else begin
         if (wr_hit) begin
            dirty_q[set][hit_way] <= 1'b1;
         end
         if (wb_done) begin
            dirty_q[set][victim_q] <= 1'b0;
         end
         if (fill_done) begin
            valid_q[set][victim_q] <= 1'b1;
            dirty_q[set][victim_q] <= 1'b0;
         end
      end
   end

   // Line data and tags carry no reset; valid gates their use.
   always_ff @(posedge clk) begin
      if (wr_hit) begin
         for (int i = 0; i < 32; i++) begin
            if (bus.mem_byte_enable[i]) begin
               data_q[set][hit_way][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
            end
         end
      end
      if (fill_done) begin
         data_q[set][victim_q] <= bus.pmem_rdata;
         tag_q[set][victim_q]  <= tag;
      end
   end

endmodule

// File: tb/tb_cache_assoc_wb.sv
// Bench for cache_assoc_wb: directed scenarios plus random traffic against a timestamp-LRU
// reference model and a sparse line memory.
module tb_cache_assoc_wb;
   import cache_assoc_wb_pkg::*;

   localparam int NW = 8;
   localparam int NS = 8;

   logic clk = 1'b0;
   logic rst;

   cache_assoc_wb_if bus  ();
   cache_assoc_wb_if bus2 ();

   cache_assoc_wb #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut  (.clk(clk), .rst(rst), .bus(bus));
   cache_assoc_wb #(.NUM_WAYS(2),  .NUM_SETS(32)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   always #5 clk = ~clk;

   logic [23:0] m_tag   [NS][NW];
   bit          m_val   [NS][NW];
   bit          m_dirty [NS][NW];
   line_t       m_data  [NS][NW];
   longint      m_stamp [NS][NW];
   longint      use_clk;
   line_t       mem [logic [31:0]];
   int          n_checks;
   int          n_fail;

   task automatic check_eq(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   function automatic line_t dflt(input logic [31:0] a);
      line_t r;
      for (int k = 0; k < 8; k++) begin
         r[k*32 +: 32] = (a * 32'h9E37_79B1) ^ (32'(k) * 32'h0101_0101) ^ 32'h5A5A_C3C3;
      end
      return r;
   endfunction

   function automatic line_t mem_get(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return dflt(a);
   endfunction

   function automatic line_t rand_line();
      line_t r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < NS; s++) begin
         for (int w = 0; w < NW; w++) begin
            m_val[s][w]   = 1'b0;
            m_dirty[s][w] = 1'b0;
            m_stamp[s][w] = -longint'(w);
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.pmem_resp = 1'b0;
      bus2.mem_read = 1'b0;
      bus2.pmem_resp = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      check_eq("rst_mem_resp",   256'(bus.mem_resp),   256'(0));
      check_eq("rst_pmem_read",  256'(bus.pmem_read),  256'(0));
      check_eq("rst_pmem_write", 256'(bus.pmem_write), 256'(0));
   endtask

   task automatic access(input logic [31:0] addr, input bit we, input bit both,
                         input logic [31:0] be, input line_t wd,
                         output bit wb_seen, output logic [31:0] wb_addr, output line_t rdata);
      logic [2:0]  s;
      logic [23:0] t;
      logic [31:0] la, exp_wb_addr;
      line_t       exp_wb_data, exp_line;
      bit          hit, exp_wb, fill_seen, done, busy;
      int          hw, cyc, lat, fill_cyc;
      s = addr[7:5];
      t = addr[31:8];
      la = {addr[31:5], 5'b0};
      hit = 1'b0; hw = 0; exp_wb = 1'b0; exp_wb_addr = '0; exp_wb_data = '0;
      for (int w = 0; w < NW; w++) begin
         if (m_val[s][w] && m_tag[s][w] == t) begin
            hit = 1'b1;
            hw = w;
         end
      end
      if (!hit) begin
         hw = -1;
         for (int w = 0; w < NW; w++) if (!m_val[s][w] && hw < 0) hw = w;
         if (hw < 0) begin
            hw = 0;
            for (int w = 1; w < NW; w++) if (m_stamp[s][w] < m_stamp[s][hw]) hw = w;
         end
         if (m_val[s][hw] && m_dirty[s][hw]) begin
            exp_wb      = 1'b1;
            exp_wb_addr = {m_tag[s][hw], s, 5'b0};
            exp_wb_data = m_data[s][hw];
         end
      end
      exp_line = hit ? m_data[s][hw] : mem_get(la);

      @(negedge clk);
      bus.mem_address     = addr;
      bus.mem_write       = we;
      bus.mem_read        = !we || both;
      bus.mem_byte_enable = be;
      bus.mem_wdata       = wd;
      wb_seen = 1'b0; wb_addr = '0; rdata = '0; fill_seen = 1'b0;
      done = 1'b0; busy = 1'b0; cyc = 0; lat = 0; fill_cyc = -10;
      while (!done && cyc < 200) begin
         #1;
         if (bus.mem_resp) begin
            done  = 1'b1;
            rdata = bus.mem_rdata;
            check_eq("rdata", bus.mem_rdata, exp_line);
            check_eq("resp_latency", 256'(cyc), hit ? 256'(0) : 256'(fill_cyc + 1));
         end else if (bus.pmem_write || bus.pmem_read) begin
            if (!busy) begin
               busy = 1'b1;
               lat  = $urandom_range(0, 3);
               if (bus.pmem_write) begin
                  wb_seen = 1'b1;
                  wb_addr = bus.pmem_address;
                  check_eq("wb_addr", 256'(bus.pmem_address), 256'(exp_wb_addr));
                  check_eq("wb_data", bus.pmem_wdata, exp_wb_data);
                  mem[exp_wb_addr] = exp_wb_data;
               end else begin
                  fill_seen = 1'b1;
                  check_eq("fill_addr", 256'(bus.pmem_address), 256'(la));
                  check_eq("wb_before_fill", 256'(wb_seen), 256'(exp_wb));
               end
            end
            if (lat == 0) begin
               bus.pmem_rdata = bus.pmem_read ? mem_get(la) : rand_line();
               bus.pmem_resp  = 1'b1;
               busy = 1'b0;
               if (bus.pmem_read) fill_cyc = cyc;
            end else begin
               lat--;
            end
         end
         @(negedge clk);
         bus.pmem_resp = 1'b0;
         cyc++;
      end
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      check_eq("resp_seen", 256'(done),      256'(1));
      check_eq("wb_seen",   256'(wb_seen),   256'(exp_wb));
      check_eq("fill_seen", 256'(fill_seen), 256'(!hit));

      if (!hit) begin
         m_tag[s][hw]   = t;
         m_val[s][hw]   = 1'b1;
         m_dirty[s][hw] = 1'b0;
         m_data[s][hw]  = mem_get(la);
      end
      if (we) begin
         for (int i = 0; i < 32; i++) if (be[i]) m_data[s][hw][8*i +: 8] = wd[8*i +: 8];
         m_dirty[s][hw] = 1'b1;
      end
      use_clk++;
      m_stamp[s][hw] = use_clk;
   endtask

   task automatic access2(input logic [31:0] addr, input bit exp_miss);
      logic [31:0] la;
      bit          done, fill_seen;
      int          cyc;
      la = {addr[31:5], 5'b0};
      @(negedge clk);
      bus2.mem_address = addr;
      bus2.mem_read    = 1'b1;
      done = 1'b0; fill_seen = 1'b0; cyc = 0;
      while (!done && cyc < 50) begin
         #1;
         if (bus2.mem_resp) begin
            done = 1'b1;
            check_eq("d2_rdata", bus2.mem_rdata, dflt(la));
         end else if (bus2.pmem_read) begin
            if (!fill_seen) check_eq("d2_fill_addr", 256'(bus2.pmem_address), 256'(la));
            fill_seen       = 1'b1;
            bus2.pmem_rdata = dflt(la);
            bus2.pmem_resp  = 1'b1;
         end
         @(negedge clk);
         bus2.pmem_resp = 1'b0;
         cyc++;
      end
      bus2.mem_read = 1'b0;
      check_eq("d2_resp", 256'(done),      256'(1));
      check_eq("d2_miss", 256'(fill_seen), 256'(exp_miss));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      bit          wb;
      logic [31:0] wba;
      line_t       rd;
      n_checks = 0;
      n_fail   = 0;
      use_clk  = 0;
      rst = 1'b1;
      bus.mem_address = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      bus.mem_byte_enable = '0; bus.mem_wdata = '0; bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
      bus2.mem_address = '0; bus2.mem_read = 1'b0; bus2.mem_write = 1'b0;
      bus2.mem_byte_enable = '0; bus2.mem_wdata = '0; bus2.pmem_rdata = '0; bus2.pmem_resp = 1'b0;

      // cold read miss goes straight to fill
      apply_reset();
      access(32'h0000_0100, 1'b0, 1'b0, '0, '0, wb, wba, rd);
      check_eq("t1_rdata", rd, dflt(32'h0000_0100));
      check_eq("t1_no_wb", 256'(wb), 256'(0));

      // partial write hit on a zero line
      apply_reset();
      mem[32'h0] = '0;
      access(32'h0, 1'b0, 1'b0, '0, '0, wb, wba, rd);
      access(32'h0, 1'b1, 1'b0, 32'h0000_000F, '1, wb, wba, rd);
      access(32'h0, 1'b0, 1'b0, '0, '0, wb, wba, rd);
      check_eq("t2_bytes", rd, 256'hFFFF_FFFF);

      // overflow set 0: dirty way 0 is written back first
      for (int t = 1; t <= NW; t++) begin
         access(32'(t) << 8, 1'b0, 1'b0, '0, '0, wb, wba, rd);
      end
      check_eq("t3_wb_seen", 256'(wb),  256'(1));
      check_eq("t3_wb_addr", 256'(wba), 256'(0));
      access(32'h0, 1'b0, 1'b0, '0, '0, wb, wba, rd);
      check_eq("t3_refetch", rd, 256'hFFFF_FFFF);

      // re-used way 0 survives, way 1 becomes the victim
      apply_reset();
      for (int t = 0; t < NW; t++) begin
         access((32'(t) << 8) | 32'h40, 1'b1, 1'b0, 32'hFFFF_FFFF, rand_line(), wb, wba, rd);
      end
      access(32'h40, 1'b0, 1'b0, '0, '0, wb, wba, rd);
      access(32'h840, 1'b0, 1'b0, '0, '0, wb, wba, rd);
      check_eq("t4_wb_seen", 256'(wb),  256'(1));
      check_eq("t4_wb_addr", 256'(wba), 256'(32'h140));

      // reset in the middle of a fill abandons it
      apply_reset();
      @(negedge clk);
      bus.mem_address = 32'h300;
      bus.mem_read    = 1'b1;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (bus.pmem_read) break;
         @(negedge clk);
      end
      check_eq("t5_fill_req", 256'(bus.pmem_read), 256'(1));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_eq("t5_read_drop", 256'(bus.pmem_read), 256'(0));
      check_eq("t5_no_resp",   256'(bus.mem_resp),   256'(0));
      rst = 1'b0;
      bus.mem_read = 1'b0;
      model_reset();
      access(32'h300, 1'b0, 1'b0, '0, '0, wb, wba, rd);

      // 2-way / 32-set build
      access2(32'h0000_0020, 1'b1);
      access2(32'h0000_0420, 1'b1);
      access2(32'h0000_0020, 1'b0);
      access2(32'h0000_0420, 1'b0);

      // random traffic over a few contended sets
      apply_reset();
      for (int n = 0; n < 400; n++) begin
         logic [31:0] a;
         bit          we;
         a  = ({8'h0, 24'($urandom_range(0, 11))} << 8) | (32'($urandom_range(0, 3)) << 5)
              | 32'($urandom_range(0, 31));
         we = $urandom_range(0, 1) == 1;
         access(a, we, $urandom_range(0, 3) == 0, $urandom, rand_line(), wb, wba, rd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
